// File: rtl/regfile_writer.sv
// Write-side controller for the 32x32 register file: sweeps the file to its
// initial state after reset, then drains buffered ALU/load results one per cycle.
module regfile_writer #(
   parameter int          DEPTH   = 4,
   parameter int          SP_REG  = 29,
   parameter logic [31:0] SP_INIT = 32'd252
) (
   input  logic        elk,
   input  logic        nrst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_addr,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_addr,
   input  logic [31:0] mem_data,
   output logic        wr_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        init_done,
   output logic [31:0] busy_mask
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [4:0]  SP_ADDR  = 5'(SP_REG);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [4:0]        init_cnt;

   logic [4:0]        fifo_addr [DEPTH];
   logic [31:0]       fifo_data [DEPTH];
   logic [DEPTH-1:0]  entry_vld;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [AW:0]       count;
   logic              out_is_result;

   logic              full;
   logic              mem_fire;
   logic              alu_fire;
   logic              push;
   logic              pop;
   logic [4:0]        push_addr;
   logic [31:0]       push_data;

   // Loads win over ALU results so at most one entry is pushed per cycle;
   // results aimed at r0 still handshake but never enter the queue.
   always_comb begin
      full      = (count == FULL_CNT);
      mem_ready = (state == RUN) && !full;
      alu_ready = (state == RUN) && !full && !mem_valid;
      mem_fire  = mem_valid && mem_ready;
      alu_fire  = alu_valid && alu_ready;
      push_addr = mem_fire ? mem_addr : alu_addr;
      push_data = mem_fire ? mem_data : alu_data;
      push      = (mem_fire || alu_fire) && (push_addr != 5'd0);
      pop       = (state == RUN) && (count != '0);
   end

   always_comb begin
      state_next = state;
      if ((state == INIT) && (init_cnt == 5'd31)) begin
         state_next = RUN;
      end
   end

   always_ff @(posedge elk) begin
      if (nrst) begin
         state <= INIT;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge elk) begin
      if (nrst) begin
         init_cnt <= 5'd1;
      end else if (state == INIT) begin
         init_cnt <= init_cnt + 5'd1;
      end
   end

   // Payload storage needs no reset; entry_vld and count say what is live.
   always_ff @(posedge elk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= push_addr;
         fifo_data[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge elk) begin
      if (nrst) begin
         entry_vld <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
      end else begin
         if (pop) begin
            entry_vld[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + AW'(1);
         end
         if (push) begin
            entry_vld[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + (AW + 1)'(1);
         end else if (pop && !push) begin
            count <= count - (AW + 1)'(1);
         end
      end
   end

   // During INIT the write port walks r1..r31; in RUN it carries the FIFO head.
   always_ff @(posedge elk) begin
      if (nrst) begin
         wr_en         <= 1'b0;
         wr_addr       <= 5'd0;
         wr_data       <= 32'd0;
         init_done     <= 1'b0;
         out_is_result <= 1'b0;
      end else if (state == INIT) begin
         wr_en         <= 1'b1;
         wr_addr       <= init_cnt;
         wr_data       <= (init_cnt == SP_ADDR) ? SP_INIT : 32'd0;
         out_is_result <= 1'b0;
         if (init_cnt == 5'd31) begin
            init_done <= 1'b1;
         end
      end else if (pop) begin
         wr_en         <= 1'b1;
         wr_addr       <= fifo_addr[rd_ptr];
         wr_data       <= fifo_data[rd_ptr];
         out_is_result <= 1'b1;
      end else begin
         wr_en         <= 1'b0;
         out_is_result <= 1'b0;
      end
   end

   // Init sweep writes are not results, so they never mark a register busy.
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_vld[i]) begin
            busy_mask[fifo_addr[i]] = 1'b1;
         end
      end
      if (wr_en && out_is_result) begin
         busy_mask[wr_addr] = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_writer.sv
// Scoreboard bench for regfile_writer: a queue-based reference model predicts
// readies, busy mask and the ordered stream of register file writes.
module tb_regfile_writer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        elk = 1'b0;
   logic        nrst = 1'b1;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_addr = '0;
   logic [31:0] alu_data = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [4:0]  mem_addr = '0;
   logic [31:0] mem_data = '0;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        init_done;
   logic [31:0] busy_mask;

   int checks = 0;
   int errors = 0;

   wr_t sb[$];
   wr_t pend[$];
   bit  m_run;
   int  m_cnt;
   bit  m_wr;
   bit  m_out_valid;
   logic [4:0] m_out_addr;

   regfile_writer #(.DEPTH(DEPTH), .SP_REG(29), .SP_INIT(32'd252)) dut (
      .elk(elk), .nrst(nrst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .init_done(init_done), .busy_mask(busy_mask)
   );

   always #5 elk = ~elk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] modelBusy();
      logic [31:0] m;
      m = '0;
      foreach (pend[i]) m[pend[i].a] = 1'b1;
      if (m_out_valid) m[m_out_addr] = 1'b1;
      return m;
   endfunction

   // Advance the reference model across one clock edge.
   task automatic modelEdge(input bit acc, input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      if (!m_run) begin
         m_wr = 1'b1;
         m_out_valid = 1'b0;
         if (m_cnt == 31) m_run = 1'b1;
         m_cnt++;
      end else begin
         if (pend.size() > 0) begin
            e = pend.pop_front();
            m_wr = 1'b1;
            m_out_valid = 1'b1;
            m_out_addr = e.a;
         end else begin
            m_wr = 1'b0;
            m_out_valid = 1'b0;
         end
         if (acc && a != 5'd0) begin
            e.a = a;
            e.d = d;
            pend.push_back(e);
            sb.push_back(e);
         end
      end
   endtask

   task automatic applyStimulus(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                                input bit av, input logic [4:0] aa, input logic [31:0] ad);
      bit exp_mr, exp_ar;
      @(negedge elk);
      #1;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      alu_valid = av; alu_addr = aa; alu_data = ad;
      #1;
      exp_mr = m_run && (pend.size() < DEPTH);
      exp_ar = exp_mr && !mv;
      checkOutput("mem_ready", 32'(mem_ready), 32'(exp_mr));
      checkOutput("alu_ready", 32'(alu_ready), 32'(exp_ar));
      checkOutput("init_done", 32'(init_done), 32'(m_run));
      checkOutput("wr_en", 32'(wr_en), 32'(m_wr));
      checkOutput("busy_mask", busy_mask, modelBusy());
      if (mv && exp_mr) modelEdge(1'b1, ma, md);
      else if (av && exp_ar) modelEdge(1'b1, aa, ad);
      else modelEdge(1'b0, 5'd0, 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic applyReset(input int n);
      wr_t e;
      @(negedge elk);
      #1;
      nrst = 1'b1;
      mem_valid = 1'b0;
      alu_valid = 1'b0;
      sb.delete();
      pend.delete();
      m_run = 1'b0; m_cnt = 1; m_wr = 1'b0; m_out_valid = 1'b0; m_out_addr = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge elk);
         #2;
         checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
         checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
         checkOutput("rst_wr_data", wr_data, 32'd0);
         checkOutput("rst_init_done", 32'(init_done), 32'd0);
         checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
         checkOutput("rst_alu_ready", 32'(alu_ready), 32'd0);
         checkOutput("rst_busy_mask", busy_mask, 32'd0);
      end
      nrst = 1'b0;
      for (int r = 1; r < 32; r++) begin
         e.a = 5'(r);
         e.d = (r == 29) ? 32'd252 : 32'd0;
         sb.push_back(e);
      end
      modelEdge(1'b0, 5'd0, 32'd0);
   endtask

   // Monitor: every cycle the port writes, the oldest expected write must match.
   initial begin
      wr_t e;
      forever begin
         @(negedge elk);
         if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               checkOutput("wr_addr", 32'(wr_addr), 32'(e.a));
               checkOutput("wr_data", wr_data, e.d);
            end
         end
      end
   end

   initial begin
      applyReset(2);
      idle(34);

      applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
      idle(3);
      applyStimulus(1, 5'd7, 32'h11, 1, 5'd8, 32'h22);
      applyStimulus(0, 0, 0, 1, 5'd8, 32'h22);
      idle(3);
      applyStimulus(0, 0, 0, 1, 5'd0, 32'h1234);
      idle(3);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 5'(10 + i), 32'(100 + i));
      for (int i = 0; i < 6; i++) applyStimulus(1, 5'(3), 32'(200 + i), 0, 0, 0);
      idle(3);

      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 2) == 0, 5'($urandom), $urandom,
                       $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
      end

      applyStimulus(0, 0, 0, 1, 5'd20, 32'hA);
      applyStimulus(1, 5'd21, 32'hB, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 5'd22, 32'hC);
      applyReset(2);
      idle(40);
      for (int i = 0; i < 100; i++) begin
         applyStimulus($urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                       $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
      end
      idle(5);

      checkOutput("drain_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
